// File: rtl/fetch_stage.sv
// Instruction fetch stage: issues PC requests to instruction memory over a
// req/ack handshake, captures the returned word into an output register that
// decode drains via valid/ready, drives the PC load enable, discards responses
// that belong to a flushed path and raises a sticky timeout flag.
//
// Handshakes:
//   imem: a request (o_imem_req, o_imem_addr) is held stable from the cycle
//         it rises through its ack cycle inclusive; an ack is honoured in any
//         cycle where o_imem_req=1, including the first one.
//   inst: a transfer happens in every cycle with o_inst_valid && i_inst_ready;
//         o_inst/o_inst_pc are stable while o_inst_valid=1 and not accepted.
module fetch_stage #(
  parameter int TIMEOUT = 15
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_pc,
  output logic        o_pc_en,
  input  logic        i_flush,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ack,
  input  logic [31:0] i_imem_rdata,
  output logic        o_inst_valid,
  input  logic        i_inst_ready,
  output logic [31:0] o_inst,
  output logic [31:0] o_inst_pc,
  output logic        o_fetch_err,
  output logic [1:0]  o_state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DROP  = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [31:0] r_req_addr;
  logic        r_inst_valid;
  logic [31:0] r_inst;
  logic [31:0] r_inst_pc;
  logic [7:0]  r_to_cnt;
  logic [7:0]  w_to_cnt_next;
  logic        r_fetch_err;
  logic        w_capture;
  logic        w_clear_valid;

  assign o_state      = r_state;
  assign o_inst_valid = r_inst_valid;
  assign o_inst       = r_inst;
  assign o_inst_pc    = r_inst_pc;
  assign o_fetch_err  = r_fetch_err;

  // State register; reset drops any outstanding request immediately.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  // Next-state, memory request, PC enable and capture/clear strobes.
  always_comb begin
    w_state_next  = r_state;
    o_imem_req    = 1'b0;
    o_imem_addr   = 32'd0;
    o_pc_en       = 1'b0;
    w_capture     = 1'b0;
    w_clear_valid = i_flush;
    case (r_state)
      ST_IDLE: w_state_next = ST_FETCH;
      ST_FETCH: begin
        o_imem_req  = 1'b1;
        o_imem_addr = i_pc;
        if (i_imem_ack && !i_flush) begin
          o_pc_en      = 1'b1;
          w_capture    = 1'b1;
          w_state_next = ST_HOLD;
        end else if (!i_imem_ack && i_flush) begin
          // The request cannot be withdrawn; finish it and throw the data away.
          w_state_next = ST_DROP;
        end
      end
      ST_HOLD: begin
        if (i_flush || (r_inst_valid && i_inst_ready)) begin
          w_clear_valid = 1'b1;
          w_state_next  = ST_FETCH;
        end
      end
      ST_DROP: begin
        o_imem_req  = 1'b1;
        o_imem_addr = r_req_addr;
        if (i_imem_ack) w_state_next = ST_FETCH;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Remember the address of the request issued from FETCH so DROP can keep it stable.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                    r_req_addr <= 32'd0;
    else if (r_state == ST_FETCH) r_req_addr <= i_pc;
  end

  // Output holding register; inst/inst_pc keep stale values when valid drops.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_inst_valid <= 1'b0;
      r_inst       <= 32'd0;
      r_inst_pc    <= 32'd0;
    end else if (w_capture) begin
      r_inst_valid <= 1'b1;
      r_inst       <= i_imem_rdata;
      r_inst_pc    <= i_pc;
    end else if (w_clear_valid) begin
      r_inst_valid <= 1'b0;
    end
  end

  // Count consecutive unacknowledged request cycles, saturating at 255.
  always_comb begin
    w_to_cnt_next = r_to_cnt;
    if (o_imem_req) begin
      if (i_imem_ack)              w_to_cnt_next = 8'd0;
      else if (r_to_cnt != 8'hFF)  w_to_cnt_next = r_to_cnt + 8'd1;
    end
  end

  // Timeout counter and sticky error flag (cleared only by reset).
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_to_cnt    <= 8'd0;
      r_fetch_err <= 1'b0;
    end else begin
      r_to_cnt <= w_to_cnt_next;
      if (w_to_cnt_next >= 8'(TIMEOUT)) r_fetch_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: a PC register, a latency-programmable instruction
// memory, a decode-side ready driver and a scoreboard of expected
// {inst_pc, inst} pairs, stepped one clock at a time by directed steps.
module tb_fetch_stage;
  localparam int TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] i_pc = 32'd0;
  logic        o_pc_en;
  logic        i_flush = 1'b0;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_ack = 1'b0;
  logic [31:0] i_imem_rdata = 32'd0;
  logic        o_inst_valid;
  logic        i_inst_ready = 1'b0;
  logic [31:0] o_inst;
  logic [31:0] o_inst_pc;
  logic        o_fetch_err;
  logic [1:0]  o_state;

  fetch_stage #(.TIMEOUT(TIMEOUT)) dut (
    .i_clk(clk), .i_rst(rst), .i_pc(i_pc), .o_pc_en(o_pc_en), .i_flush(i_flush),
    .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr), .i_imem_ack(i_imem_ack),
    .i_imem_rdata(i_imem_rdata), .o_inst_valid(o_inst_valid), .i_inst_ready(i_inst_ready),
    .o_inst(o_inst), .o_inst_pc(o_inst_pc), .o_fetch_err(o_fetch_err), .o_state(o_state)
  );

  // Clock
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];

  // Environment models
  logic [31:0] tb_pc = 32'd0;
  bit          exp_valid = 1'b0;
  bit          exp_err = 1'b0;
  int          to_cnt = 0;
  bit          mem_busy = 1'b0;
  bit          mem_dropped = 1'b0;
  logic [31:0] mem_addr = 32'd0;
  int          mem_cnt = 0;
  int          lat = 0;
  bit          hang = 1'b0;
  bit          rdy = 1'b1;
  int          pc_en_count = 0;

  // Values sampled in the most recent step
  logic [31:0] s_req, s_addr, s_valid, s_pc_en, s_err;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h1234, ~a[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // One clock: drive inputs, respond as memory, check outputs, advance models.
  task automatic cycle(input bit fl, input logic [31:0] tgt);
    logic        ack;
    bit          pe_exp;
    logic [63:0] item;
    @(negedge clk);
    i_pc = tb_pc;
    i_flush = fl;
    i_inst_ready = rdy;
    #1;
    ack = 1'b0;
    if (o_imem_req) begin
      if (mem_busy) chk("addr_stable", o_imem_addr, mem_addr);
      else begin
        chk("req_addr", o_imem_addr, tb_pc);
        mem_busy = 1'b1;
        mem_addr = o_imem_addr;
        mem_cnt = 0;
      end
      ack = !hang && (mem_cnt >= lat);
    end
    i_imem_ack = ack;
    i_imem_rdata = ack ? mem_word(mem_addr) : $urandom();
    #1;
    pe_exp = ack && !mem_dropped && !fl;
    chk("pc_en", 32'(o_pc_en), 32'(pe_exp));
    chk("inst_valid", 32'(o_inst_valid), 32'(exp_valid));
    chk("fetch_err", 32'(o_fetch_err), 32'(exp_err));
    if (o_inst_valid) chk("req_while_valid", 32'(o_imem_req), 32'd0);
    s_req = 32'(o_imem_req);
    s_addr = o_imem_addr;
    s_valid = 32'(o_inst_valid);
    s_pc_en = 32'(o_pc_en);
    s_err = 32'(o_fetch_err);
    if (o_inst_valid && rdy) begin
      chk("sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        item = exp_q.pop_front();
        chk("inst_pc", o_inst_pc, item[63:32]);
        chk("inst", o_inst, item[31:0]);
      end
    end
    if (pe_exp) begin
      exp_q.push_back({mem_addr, mem_word(mem_addr)});
      pc_en_count++;
    end
    if (fl) exp_valid = 1'b0;
    else if (pe_exp) exp_valid = 1'b1;
    else if (exp_valid && rdy) exp_valid = 1'b0;
    if (o_imem_req) begin
      if (ack) begin
        to_cnt = 0;
        mem_busy = 1'b0;
        mem_dropped = 1'b0;
      end else begin
        if (to_cnt < 255) to_cnt++;
        if (to_cnt >= TIMEOUT) exp_err = 1'b1;
        mem_cnt++;
        if (fl) mem_dropped = 1'b1;
      end
    end
    if (fl) tb_pc = tgt;
    else if (pe_exp) tb_pc = tb_pc + 32'd4;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req"}, 32'(o_imem_req), 32'd0);
    chk({tag, "_addr"}, o_imem_addr, 32'd0);
    chk({tag, "_pc_en"}, 32'(o_pc_en), 32'd0);
    chk({tag, "_valid"}, 32'(o_inst_valid), 32'd0);
    chk({tag, "_inst"}, o_inst, 32'd0);
    chk({tag, "_inst_pc"}, o_inst_pc, 32'd0);
    chk({tag, "_err"}, 32'(o_fetch_err), 32'd0);
    chk({tag, "_state_idle"}, 32'(o_state), 32'd0);
  endtask

  int base;

  initial begin
    // Reset
    #12;
    chk_reset_outputs("rst0");
    @(posedge clk);
    #1 rst = 1'b0;

    // Zero-wait memory, decode always ready: one instruction every 2 cycles
    lat = 0; rdy = 1'b1; hang = 1'b0;
    cycle(1'b0, 32'd0);
    chk("t1_idle_no_req", s_req, 32'd0);
    cycle(1'b0, 32'd0);
    chk("t1_first_req", s_req, 32'd1);
    chk("t1_first_addr", s_addr, 32'd0);
    chk("t1_first_pc_en", s_pc_en, 32'd1);
    cycle(1'b0, 32'd0);
    chk("t1_valid_after_ack", s_valid, 32'd1);
    chk("t1_no_req_in_hold", s_req, 32'd0);
    cycle(1'b0, 32'd0);
    chk("t1_second_addr", s_addr, 32'd4);
    repeat (3) cycle(1'b0, 32'd0);
    chk("t1_three_insts", 32'(pc_en_count), 32'd3);
    chk("t1_third_valid", s_valid, 32'd1);

    // Memory with 2 wait states
    lat = 2;
    base = pc_en_count;
    repeat (3) cycle(1'b0, 32'd0);
    chk("t2_one_pc_en", 32'(pc_en_count - base), 32'd1);
    chk("t2_ack_cycle_req", s_req, 32'd1);
    cycle(1'b0, 32'd0);
    chk("t2_valid_after_ack", s_valid, 32'd1);

    // Decode stalls 4 cycles with a valid instruction
    lat = 0;
    cycle(1'b0, 32'd0);
    rdy = 1'b0;
    base = pc_en_count;
    repeat (4) cycle(1'b0, 32'd0);
    chk("t3_still_valid", s_valid, 32'd1);
    chk("t3_no_pc_en", 32'(pc_en_count - base), 32'd0);
    rdy = 1'b1;
    cycle(1'b0, 32'd0);
    cycle(1'b0, 32'd0);
    chk("t3_next_req", s_req, 32'd1);
    chk("t3_next_addr", s_addr, 32'd20);
    cycle(1'b0, 32'd0);

    // Flush during the 2nd wait cycle of a 4-cycle request, redirect to 0x40
    lat = 3;
    base = pc_en_count;
    cycle(1'b0, 32'd0);
    cycle(1'b1, 32'h40);
    cycle(1'b0, 32'd0);
    chk("t4_drop_addr", s_addr, 32'd24);
    cycle(1'b0, 32'd0);
    chk("t4_no_pc_en", 32'(pc_en_count - base), 32'd0);
    chk("t4_no_valid", s_valid, 32'd0);
    lat = 0;
    cycle(1'b0, 32'd0);
    chk("t4_target_addr", s_addr, 32'h40);
    cycle(1'b0, 32'd0);
    chk("t4_target_valid", s_valid, 32'd1);

    // Flush coincident with ack, redirect to 0x80
    cycle(1'b1, 32'h80);
    chk("t5_ack_req", s_req, 32'd1);
    cycle(1'b0, 32'd0);
    chk("t5_target_req", s_req, 32'd1);
    chk("t5_target_addr", s_addr, 32'h80);
    cycle(1'b0, 32'd0);
    chk("t5_target_valid", s_valid, 32'd1);

    // Stalled memory: sticky timeout, then asynchronous reset mid-request
    hang = 1'b1;
    repeat (15) cycle(1'b0, 32'd0);
    chk("t6_err_low_at_15", s_err, 32'd0);
    cycle(1'b0, 32'd0);
    chk("t6_err_set", s_err, 32'd1);
    repeat (4) cycle(1'b0, 32'd0);
    hang = 1'b0;
    cycle(1'b0, 32'd0);
    chk("t6_late_ack_pc_en", s_pc_en, 32'd1);
    cycle(1'b0, 32'd0);
    chk("t6_err_sticky", s_err, 32'd1);
    hang = 1'b1;
    repeat (2) cycle(1'b0, 32'd0);
    chk("t6_waiting_req", s_req, 32'd1);
    chk("t6_sb_empty", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk_reset_outputs("rst_async");
    tb_pc = 32'd0; exp_valid = 1'b0; exp_err = 1'b0; to_cnt = 0;
    mem_busy = 1'b0; mem_dropped = 1'b0; mem_cnt = 0; exp_q.delete();
    hang = 1'b0; lat = 0;
    @(posedge clk);
    #1 rst = 1'b0;
    cycle(1'b0, 32'd0);
    chk("t7_idle_no_req", s_req, 32'd0);
    cycle(1'b0, 32'd0);
    chk("t7_restart_addr", s_addr, 32'd0);
    cycle(1'b0, 32'd0);
    chk("t7_restart_valid", s_valid, 32'd1);
    chk("t7_err_cleared", s_err, 32'd0);
    chk("final_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage between the PC register and decode. Presents the current PC to instruction memory over a req/ack handshake and holds the request through wait states. Captures the returned word with its PC into an output register that decode consumes via valid/ready. Generates the PC register load enable, discards responses on flush, and flags stalled memory with a sticky timeout error.

## Interface
- TIMEOUT, 15: number of consecutive unacknowledged request cycles that sets fetch_err (1..255)
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- pc  in  32  current PC from the PC register
- pc_en  out  1  PC register load enable; PC takes next_PC (PC+4) on the clk edge where pc_en=1
- flush  in  1  redirect; PC is already being loaded with the target by upstream logic this cycle
- imem_req  out  1  instruction memory request
- imem_addr  out  32  request address
- imem_ack  in  1  one-cycle acknowledge; imem_rdata valid in the same cycle
- imem_rdata  in  32  instruction word
- inst_valid  out  1  inst/inst_pc hold a valid instruction
- inst_ready  in  1  decode accepts this cycle
- inst  out  32  captured instruction
- inst_pc  out  32  PC of inst
- fetch_err  out  1  sticky timeout flag

## Operation
- States: IDLE, FETCH, HOLD, DROP.
- IDLE: entered on reset. No request. Unconditionally moves to FETCH next cycle.
- FETCH: imem_req=1, imem_addr=pc. On imem_ack with flush=0:
  - inst<=imem_rdata, inst_pc<=imem_addr, inst_valid<=1
  - pc_en=1 in the same cycle
  - next state HOLD
- FETCH, imem_ack=1 with flush=1: data discarded, pc_en=0, stay FETCH.
- FETCH, imem_ack=0 with flush=1: go to DROP.
- HOLD: no request. When inst_valid && inst_ready, inst_valid<=0 and go to FETCH. flush=1 clears inst_valid and goes to FETCH regardless of inst_ready.
- DROP: imem_req stays 1 and imem_addr is held at the flushed address, because the memory protocol forbids withdrawing a request. On imem_ack, discard the data and go to FETCH. pc_en stays 0. A flush in DROP stays in DROP.
- Memory rule: once imem_req rises, it and imem_addr stay stable until the ack cycle inclusive. An ack is honoured in any cycle with imem_req=1, including the first.
- pc_en is combinational: (state==FETCH) & imem_ack & ~flush. It is never asserted in IDLE, HOLD or DROP.
- Timeout counter (8 bits):
  - increments on each cycle with imem_req=1 and imem_ack=0, saturating at 255
  - clears on ack
  - when it reaches TIMEOUT, fetch_err<=1, cleared only by rst
  - the request continues; no abort
- Holding registers clear only on rst. On flush only inst_valid drops; inst and inst_pc keep their stale values.

## Timing
- Reset (async, immediate): state=IDLE, imem_req=0, imem_addr=0, inst_valid=0, inst=0, inst_pc=0, fetch_err=0, counter=0, pc_en=0.
- First request is in the 2nd cycle after rst deasserts (cycle 0 IDLE, cycle 1 FETCH).
- Ack in cycle k:
  - inst_valid=1 and PC=old+4 from cycle k+1
  - decode accepting in k+1 gives the next request in k+2
- Peak throughput with zero-wait memory and inst_ready=1: one instruction per 2 cycles.
- Flush in cycle k: inst_valid=0 from k+1. The first request for the target address is issued in k+1 from FETCH/HOLD, or in the cycle after the outstanding ack from DROP.
- Reset mid-request drops imem_req asynchronously. The memory shares rst.

## Test plan
- Zero-wait memory, inst_ready=1, PC reset 0 → inst_pc 0x0, 0x4, 0x8 with inst_valid high on alternate cycles; pc_en pulses on each ack cycle; fetch_err stays 0.
- Memory acks 3 cycles after req → imem_req held 3 cycles with constant imem_addr; inst_valid rises the cycle after the ack; exactly one pc_en pulse per instruction.
- inst_ready=0 for 4 cycles while inst_valid=1 → inst/inst_pc stable, imem_req=0, pc_en=0; on inst_ready=1, next req to the following PC+4 address.
- flush in 2nd wait cycle of a 4-cycle ack at addr 0x8, PC redirected to 0x40 → req held at 0x8 until ack, data discarded, no pc_en, inst_valid stays 0; next req addr 0x40, then inst_pc=0x40.
- flush coincident with ack at 0x10, redirect to 0x80 → no capture, no pc_en, next cycle req to 0x80.
- No ack for 20 cycles with TIMEOUT=15 → fetch_err rises after the 15th unacked cycle and stays high after a later ack; assert rst mid-wait → all outputs 0 immediately, fetch_err cleared.
